// File: rtl/pipeline_controller.sv
// Control and hazard unit for a 5-stage RV32I pipeline: decode in D, control
// pipeline D/E -> E/M -> M/W, branch resolution in E, stall/flush/forwarding.
module pipeline_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             blt,
    input  logic             bge,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    output logic [2:0]       ImmSrcD,
    output logic             ALUSrcE,
    output logic [2:0]       ALUControlE,
    output logic             MemWriteM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_NONE = 7'b0000000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SLTU  = 3'b101;
    localparam logic [2:0] ALU_BUFFB = 3'b110;
    localparam logic [2:0] ALU_XOR   = 3'b111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] func3;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } de_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } em_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } mw_t;

    // Only R-type uses func7[5] to select SUB; addi ignores it.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [2:0] ctrl;
        case (f3)
            3'b000:  ctrl = (is_r & f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b110:  ctrl = ALU_OR;
            3'b111:  ctrl = ALU_AND;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    // M-stage result has priority because it is the younger producer.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    de_t              dec_s;
    logic [2:0]       imm_src_s;
    logic             illegal_op_s;
    logic             taken_s;
    logic             pc_src_s;
    logic             lw_stall_s;

    de_t              de_d, de_q;
    em_t              em_d, em_q;
    mw_t              mw_d, mw_q;
    logic [CNT_W-1:0] instret_d, instret_q;
    logic             illegal_d, illegal_q;

    // D-stage instruction decode.
    always_comb begin
        dec_s        = '0;
        imm_src_s    = 3'b000;
        illegal_op_s = 1'b0;
        dec_s.func3  = func3;
        case (op)
            OP_R: begin
                dec_s.valid     = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_ctrl  = alu_dec(func3, func7[5], 1'b1);
            end
            OP_I: begin
                dec_s.valid     = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_ctrl  = alu_dec(func3, func7[5], 1'b0);
            end
            OP_LW: begin
                dec_s.valid      = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.result_src = 2'b01;
            end
            OP_SW: begin
                dec_s.valid     = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                imm_src_s       = 3'b001;
            end
            OP_B: begin
                dec_s.valid    = 1'b1;
                dec_s.branch   = 1'b1;
                dec_s.alu_ctrl = ALU_SUB;
                imm_src_s      = 3'b010;
            end
            OP_JAL: begin
                dec_s.valid      = 1'b1;
                dec_s.jump       = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.result_src = 2'b10;
                imm_src_s        = 3'b011;
            end
            OP_LUI: begin
                dec_s.valid     = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_ctrl  = ALU_BUFFB;
                imm_src_s       = 3'b100;
            end
            OP_NONE: begin
                dec_s.func3 = 3'b000;
            end
            default: begin
                dec_s.func3  = 3'b000;
                illegal_op_s = 1'b1;
            end
        endcase
    end

    // Branch resolution and hazard detection.
    always_comb begin
        case (de_q.func3)
            3'b000:  taken_s = zero;
            3'b001:  taken_s = ~zero;
            3'b100:  taken_s = blt;
            3'b101:  taken_s = bge;
            default: taken_s = 1'b0;
        endcase
        pc_src_s   = de_q.jump | (de_q.branch & taken_s);
        lw_stall_s = (de_q.result_src == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Next-state for the control pipeline, retire counter and sticky flag.
    always_comb begin
        if (lw_stall_s || pc_src_s) begin
            de_d = '0;
        end else begin
            de_d = dec_s;
        end
        em_d = '{valid: de_q.valid, reg_write: de_q.reg_write,
                 result_src: de_q.result_src, mem_write: de_q.mem_write};
        mw_d = '{valid: em_q.valid, reg_write: em_q.reg_write, result_src: em_q.result_src};
        if (mw_q.valid) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
        illegal_d = illegal_q | (illegal_op_s & ~lw_stall_s & ~pc_src_s);
    end

    // State registers; reset discards in-flight controls immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q      <= '0;
            em_q      <= '0;
            mw_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            de_q      <= de_d;
            em_q      <= em_d;
            mw_q      <= mw_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Decoded immediate select is forced quiet while reset is held.
    assign ImmSrcD     = rst ? 3'b000 : imm_src_s;
    assign ALUSrcE     = de_q.alu_src;
    assign ALUControlE = de_q.alu_ctrl;
    assign MemWriteM   = em_q.mem_write;
    assign RegWriteW   = mw_q.reg_write;
    assign ResultSrcW  = mw_q.result_src;
    assign PCSrcE      = pc_src_s;
    assign StallF      = lw_stall_s;
    assign StallD      = lw_stall_s;
    assign FlushD      = pc_src_s;
    assign FlushE      = lw_stall_s | pc_src_s;
    assign ForwardAE   = fwd_sel(Rs1E, em_q.reg_write, RdM, mw_q.reg_write, RdW);
    assign ForwardBE   = fwd_sel(Rs2E, em_q.reg_write, RdM, mw_q.reg_write, RdW);
    assign instret     = instret_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller; the bench plays the datapath by
// driving the register indices each stage would hold.
module tb_pipeline_controller;

    logic        clk, rst;
    logic [6:0]  op, func7;
    logic [2:0]  func3;
    logic        zero, blt, bge;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [2:0]  ImmSrcD, ALUControlE;
    logic        ALUSrcE, MemWriteM, RegWriteW, PCSrcE;
    logic [1:0]  ResultSrcW, ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE, illegal;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .blt(blt), .bge(bge),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .instret(instret), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_d(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2);
        op = o; func3 = f3; func7 = f7; Rs1D = r1; Rs2D = r2;
    endtask

    task automatic set_e(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        Rs1E = r1; Rs2E = r2; RdE = rd;
    endtask

    task automatic set_mw(input logic [4:0] rm, input logic [4:0] rw);
        RdM = rm; RdW = rw;
    endtask

    task automatic drain(input int n);
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd0, 5'd0, 5'd0);
        set_mw(5'd0, 5'd0);
        zero = 1'b0; blt = 1'b0; bge = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [20:0] all_outs();
        return {ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, RegWriteW, ResultSrcW, PCSrcE,
                StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, illegal};
    endfunction

    initial begin
        rst = 1'b1;
        zero = 1'b0; blt = 1'b0; bge = 1'b0;
        set_d(7'b0100011, 3'b010, 7'd0, 5'd1, 5'd2);
        set_e(5'd1, 5'd2, 5'd1);
        set_mw(5'd1, 5'd2);
        tick();
        check("rst_outs_sw", {11'd0, all_outs()}, 32'd0);
        check("rst_instret", instret, 32'd0);
        set_d(7'b1111111, 3'b111, 7'h7f, 5'd3, 5'd4);
        tick();
        check("rst_outs_ill", {11'd0, all_outs()}, 32'd0);

        // addi x1,x0,5 reaches W three cycles after entering D
        rst = 1'b0;
        drain(1);
        set_d(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd5);
        settle();
        check("addi_immsrc", ImmSrcD, 3'b000);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        settle();
        check("addi_alusrc", ALUSrcE, 1'b1);
        check("addi_aluctl", ALUControlE, 3'b000);
        tick();
        check("addi_m_regw", RegWriteW, 1'b0);
        tick();
        check("addi_w_regw", RegWriteW, 1'b1);
        check("addi_w_res", ResultSrcW, 2'b00);
        check("addi_w_cnt", instret, 32'd0);
        tick();
        check("addi_cnt", instret, 32'd1);
        check("addi_gone", RegWriteW, 1'b0);
        drain(2);

        // add x3,x1,x2 ; sub x4,x3,x1 back to back -> ALUResultM forward
        set_d(7'b0110011, 3'b000, 7'd0, 5'd1, 5'd2);
        tick();
        set_e(5'd1, 5'd2, 5'd3);
        set_d(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1);
        settle();
        check("add_aluctl", ALUControlE, 3'b000);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd3, 5'd1, 5'd4);
        set_mw(5'd3, 5'd0);
        settle();
        check("sub_aluctl", ALUControlE, 3'b001);
        check("fwdA_m", ForwardAE, 2'b10);
        check("fwdB_m_none", ForwardBE, 2'b00);
        drain(4);

        // same pair with one bubble between -> ResultW forward
        set_d(7'b0110011, 3'b000, 7'd0, 5'd1, 5'd2);
        tick();
        set_e(5'd1, 5'd2, 5'd3);
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        tick();
        set_e(5'd0, 5'd0, 5'd0);
        set_mw(5'd3, 5'd0);
        set_d(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd3, 5'd1, 5'd4);
        set_mw(5'd0, 5'd3);
        settle();
        check("fwdA_w", ForwardAE, 2'b01);
        check("fwdB_w_none", ForwardBE, 2'b00);
        drain(4);

        // add x0,x1,x2 ; sub x4,x0,x1 -> x0 is never forwarded
        set_d(7'b0110011, 3'b000, 7'd0, 5'd1, 5'd2);
        tick();
        set_e(5'd1, 5'd2, 5'd0);
        set_d(7'b0110011, 3'b000, 7'b0100000, 5'd0, 5'd1);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd0, 5'd1, 5'd4);
        set_mw(5'd0, 5'd0);
        settle();
        check("fwdA_x0", ForwardAE, 2'b00);
        drain(4);
        check("cnt_fwd", instret, 32'd7);

        // lw x5,0(x0) ; add x6,x5,x5 -> one stall cycle then W forwarding
        set_d(7'b0000011, 3'b010, 7'd0, 5'd0, 5'd0);
        tick();
        set_e(5'd0, 5'd0, 5'd5);
        set_d(7'b0110011, 3'b000, 7'd0, 5'd5, 5'd5);
        settle();
        check("lu_stall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
        tick();
        set_e(5'd0, 5'd0, 5'd0);
        set_mw(5'd5, 5'd0);
        settle();
        check("lu_release", {StallF, StallD, FlushE, FlushD}, 4'b0000);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd5, 5'd5, 5'd6);
        set_mw(5'd0, 5'd5);
        settle();
        check("lu_fwd", {ForwardAE, ForwardBE}, 4'b0101);
        check("lu_res", ResultSrcW, 2'b01);
        drain(4);
        check("cnt_lu", instret, 32'd9);

        // beq taken, beq not taken, bge taken
        set_d(7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2);
        settle();
        check("beq_immsrc", ImmSrcD, 3'b010);
        tick();
        set_e(5'd1, 5'd2, 5'd0);
        zero = 1'b1;
        set_d(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd1);
        settle();
        check("beq_taken", {PCSrcE, FlushD, FlushE, StallF}, 4'b1110);
        tick();
        zero = 1'b0;
        set_e(5'd0, 5'd0, 5'd0);
        set_d(7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2);
        settle();
        check("beq_flushed", {PCSrcE, FlushD, FlushE}, 3'b000);
        tick();
        set_e(5'd1, 5'd2, 5'd0);
        set_d(7'b1100011, 3'b101, 7'd0, 5'd1, 5'd2);
        settle();
        check("beq_not", {PCSrcE, FlushD, FlushE}, 3'b000);
        tick();
        bge = 1'b0; blt = 1'b1;
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        settle();
        check("bge_blt_only", PCSrcE, 1'b0);
        bge = 1'b1; blt = 1'b0;
        settle();
        check("bge_taken", PCSrcE, 1'b1);
        drain(4);
        check("cnt_br", instret, 32'd12);

        // jal x1,+8 ; add x2,x1,x0 at the target
        set_d(7'b1101111, 3'b000, 7'd0, 5'd8, 5'd0);
        settle();
        check("jal_immsrc", ImmSrcD, 3'b011);
        tick();
        set_e(5'd0, 5'd0, 5'd1);
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        settle();
        check("jal_pcsrc", PCSrcE, 1'b1);
        tick();
        set_e(5'd0, 5'd0, 5'd0);
        set_mw(5'd1, 5'd0);
        set_d(7'b0110011, 3'b000, 7'd0, 5'd1, 5'd0);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        set_e(5'd1, 5'd0, 5'd2);
        set_mw(5'd0, 5'd1);
        settle();
        check("jal_res", {RegWriteW, ResultSrcW}, 3'b110);
        check("jal_fwd", {ForwardAE, ForwardBE}, 4'b0100);
        drain(4);
        check("cnt_jal", instret, 32'd14);

        // unsupported opcode sets the sticky flag
        set_d(7'b1111111, 3'b000, 7'd0, 5'd0, 5'd0);
        settle();
        check("ill_pre", illegal, 1'b0);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        settle();
        check("ill_set", illegal, 1'b1);
        tick();
        check("ill_sticky", illegal, 1'b1);

        // sw: one MemWriteM pulse, no register write
        set_d(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd3);
        settle();
        check("sw_immsrc", ImmSrcD, 3'b001);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        tick();
        check("sw_memw", MemWriteM, 1'b1);
        tick();
        check("sw_memw_end", {MemWriteM, RegWriteW}, 2'b00);
        drain(3);
        check("cnt_sw", instret, 32'd15);

        // reset mid-flight: sw in E is discarded, counters and flag clear
        set_d(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd3);
        tick();
        set_d(7'd0, 3'd0, 7'd0, 5'd0, 5'd0);
        rst = 1'b1;
        settle();
        check("mrst_cnt", instret, 32'd0);
        check("mrst_ill", illegal, 1'b0);
        tick();
        check("mrst_memw", MemWriteM, 1'b0);
        rst = 1'b0;
        tick();
        check("mrst_after", {MemWriteM, RegWriteW}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Control and hazard unit for the 5-stage RV32I pipeline datapath.
- Decodes op/func3/func7 in Decode and carries control through D/E, E/M and M/W control registers, in lockstep with the datapath pipeline registers.
- Resolves branches and jumps in Execute.
- Generates stall, flush and forwarding selects, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- op  in  7  instrD[6:0].
- func3  in  3  instrD[14:12].
- func7  in  7  instrD[31:25].
- zero, blt, bge  in  1 each  ALU flags, Execute stage.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register indices from the datapath.
- ImmSrcD  out  3  I=000, S=001, B=010, J=011, U=100.
- ALUSrcE  out  1  0=register, 1=immediate.
- ALUControlE  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 100, SLTU 101, BUFFB 110, XOR 111.
- MemWriteM  out  1  data memory write enable.
- RegWriteW  out  1  register file write enable.
- ResultSrcW  out  2  00 ALU, 01 memory, 10 PC+4.
- PCSrcE  out  1  1 = take PCTargetE.
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls.
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 ResultW, 10 ALUResultM.
- instret  out  CNT_W  count of retired valid instructions.
- illegal  out  1  sticky; set when an unsupported opcode is decoded in D.

Behaviour:
- Decode (combinational, D stage). Supported instructions:
  - R-type 0110011: add, sub (func7[5]=1), and, or, xor, slt, sltu.
  - I-ALU 0010011: addi, andi, ori, xori, slti, sltiu.
  - lw 0000011: ADD, ALUSrc=1, ResultSrc=01.
  - sw 0100011: ADD, ImmSrc S, MemWrite=1, RegWrite=0.
  - Branches 1100011: beq/bne/blt/bge, SUB, ImmSrc B.
  - jal 1101111: ImmSrc J, RegWrite=1, ResultSrc=10.
  - lui 0110111: BUFFB, ImmSrc U, ALUSrc=1.
- op==0000000 (flushed bubble): all controls 0, valid=0, not illegal.
- Any other opcode: all controls 0, valid=0, illegal set.
- Control register D/E holds {valid, RegWrite, ResultSrc, MemWrite, Jump, Branch, func3, ALUControl, ALUSrc}.
- Control register E/M holds {valid, RegWrite, ResultSrc, MemWrite}; M/W holds {valid, RegWrite, ResultSrc}.
- Register update rules:
  - On rst: all control registers, instret and illegal clear immediately.
  - FlushE at posedge: D/E loads all zeros; a bubble enters E.
  - E/M and M/W advance every cycle; they are never stalled.
- PCSrcE = JumpE | (BranchE & taken), where taken depends on func3E:
  - 000 (beq): zero.
  - 001 (bne): ~zero.
  - 100 (blt): blt.
  - 101 (bge): bge.
  - Any other func3 with BranchE: not taken.
- Load-use hazard: lwStall = (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- Hazard outputs:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - lwStall and PCSrcE are mutually exclusive by construction: a lw in E is never a branch.
- Forwarding for A (B is identical with Rs2E):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - The M stage has priority over W.
  - A jal in M never has a dependent in E, because the instruction behind it is flushed. PC+4 is therefore forwarded only via W (01).
- instret increments by 1 on each posedge where validW & ~rst; it wraps at 2^CNT_W.
- illegal sets when an unsupported opcode sits in D, StallD=0 and FlushD=0. Only rst clears it.
- Reset values: every output 0, including instret. Outputs come out of reset with a 1-cycle-equivalent bubble pipeline.
- Reset asserted mid-operation: in-flight controls are discarded; no MemWriteM or RegWriteW pulses after rst rises.

Test Plan:
- Reset: hold rst with random op → every output is 0. Release rst, then feed addi x1,x0,5 → RegWriteW=1 and ResultSrcW=00 exactly 3 cycles after the instruction enters D; instret=1.
- Forwarding: add x3,x1,x2 then sub x4,x3,x1 back-to-back → ForwardAE=10 when sub is in E. With one nop between them → ForwardAE=01. With x0 as destination → 00.
- Load-use: lw x5,0(x0) then add x6,x5,x5 → StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=ForwardBE=01. The bubble does not increment instret.
- Branches: beq taken with zero=1 → PCSrcE=FlushD=FlushE=1 for 1 cycle. Not taken with zero=0 → all 0. bge with bge=1 → PCSrcE=1.
- jal x1,+8 → PCSrcE=1 in E and ResultSrcW=10 in W. A dependent add x2,x1,x0 at the target gets ForwardAE=01.
- Illegal and sw: op=1111111 in D → illegal=1 and stays 1. sw → MemWriteM=1 for 1 cycle with RegWriteW=0. rst then clears illegal.
